// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: one result bit per clock,
// shift-add multiply and restoring divide on operand magnitudes, sign applied at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int COUNT_WIDTH = $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             op_q, op_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic [2*WIDTH-1:0]     mul_step, div_step;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quot_fix, rem_fix;

    // Operand magnitudes and one iteration of each datapath; prod_q doubles as
    // {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        a_neg = ~req_unsigned & req_a[WIDTH-1];
        b_neg = ~req_unsigned & req_b[WIDTH-1];
        a_mag = a_neg ? -req_a : req_a;
        b_mag = b_neg ? -req_b : req_b;

        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
        mul_step = {mul_sum, prod_q[WIDTH-1:1]};

        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            div_step = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end

        prod_fix = neg_quot_q ? -prod_q : prod_q;
        quot_fix = neg_quot_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        opnd_d     = opnd_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            if (mthi) hi_d = wr_val;
            if (mtlo) lo_d = wr_val;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_op != OP_RSVD) begin
                    state_d    = S_CALC;
                    count_d    = '0;
                    op_d       = req_op;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    if (req_op[1]) begin
                        opnd_d = b_mag;
                        prod_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        prod_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end
            end
            S_CALC: begin
                prod_d  = op_q[1] ? div_step : mul_step;
                count_d = count_q + COUNT_WIDTH'(1);
                if (count_q == COUNT_WIDTH'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A zero divisor leaves the dividend magnitude in the remainder, so
                // re-signing it gives back req_a; only the quotient needs forcing.
                case (op_q)
                    OP_MUL:  {hi_d, lo_d} = prod_fix;
                    OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                    default: begin
                        lo_d = (opnd_q == '0) ? '1 : quot_fix;
                        hi_d = rem_fix;
                    end
                endcase
                state_d = S_IDLE;
                count_d = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
            done_d  = 1'b0;
            if (state_q != S_IDLE) begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            opnd_q     <= opnd_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: hand-computed HI/LO results, latency,
// flush, busy-time filtering and asynchronous reset.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             req_valid;
   logic [1:0]       req_op;
   logic             req_unsigned;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wr_val;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   int compareCount = 0;
   int failCount    = 0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_unsigned (req_unsigned),
      .req_a        (req_a),
      .req_b        (req_b),
      .mthi         (mthi),
      .mtlo         (mtlo),
      .wr_val       (wr_val),
      .flush        (flush),
      .busy         (busy),
      .done         (done),
      .hi           (hi),
      .lo           (lo)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   always #5 clock = ~clock;

   // Single comparison point: every check counts here and reports its own mismatch
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
      end
   endtask

   // Drives one request (optionally with MTHI/MTLO) for exactly one rising edge;
   // called and returns on a falling edge
   task automatic applyStimulus(input logic [1:0] op, input logic uns,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic mh, input logic ml, input logic [31:0] wv,
                                input logic rv);
      req_valid    = rv;
      req_op       = op;
      req_unsigned = uns;
      req_a        = a;
      req_b        = b;
      mthi         = mh;
      mtlo         = ml;
      wr_val       = wv;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      mthi      = 1'b0;
      mtlo      = 1'b0;
   endtask

   // Counts rising edges after the capture edge until done is seen, bounded
   task automatic waitDone(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         @(negedge clock);
         lat++;
      end
   endtask

   // Full operation: issue, wait, check timing and HI/LO; ends in the done cycle
   task automatic runOp(input string tag, input logic [1:0] op, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic [31:0] wv,
                        input logic [31:0] expHi, input logic [31:0] expLo);
      int   lat;
      logic busyAfterStart;
      applyStimulus(op, uns, a, b, mh, 1'b0, wv, 1'b1);
      busyAfterStart = busy;
      waitDone(lat);
      checkOutput({tag, " busy after capture"}, 64'(busyAfterStart), 64'd1);
      checkOutput({tag, " done seen"}, 64'(done), 64'd1);
      checkOutput({tag, " latency"}, 64'(lat), 64'd33);
      checkOutput({tag, " busy in done cycle"}, 64'(busy), 64'd0);
      checkOutput({tag, " hi:lo"}, {hi, lo}, {expHi, expLo});
   endtask

   // Directed scenarios in order; each result leaves HI/LO in a known state for the next
   initial begin
      int doneSeen;
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_op       = 2'b00;
      req_unsigned = 1'b0;
      req_a        = '0;
      req_b        = '0;
      mthi         = 1'b0;
      mtlo         = 1'b0;
      wr_val       = '0;
      flush        = 1'b0;

      repeat (2) @(negedge clock);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset hi:lo", {hi, lo}, 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      runOp("MULTU max*max", 2'b00, 1'b1, 32'hffffffff, 32'hffffffff, 1'b0, 32'h0, 32'hfffffffe, 32'h00000001);
      runOp("MULT -3*7",     2'b00, 1'b0, 32'hfffffffd, 32'h00000007, 1'b0, 32'h0, 32'hffffffff, 32'hffffffeb);
      runOp("MULT -3*-5",    2'b00, 1'b0, 32'hfffffffd, 32'hfffffffb, 1'b0, 32'h0, 32'h00000000, 32'h0000000f);
      runOp("DIV -7/2",      2'b10, 1'b0, 32'hfffffff9, 32'h00000002, 1'b0, 32'h0, 32'hffffffff, 32'hfffffffd);
      runOp("DIV 7/-2",      2'b10, 1'b0, 32'h00000007, 32'hfffffffe, 1'b0, 32'h0, 32'h00000001, 32'hfffffffd);
      runOp("DIVU 100/7",    2'b10, 1'b1, 32'd100,      32'd7,        1'b0, 32'h0, 32'h00000002, 32'h0000000e);
      runOp("DIVU 7/0",      2'b10, 1'b1, 32'd7,        32'd0,        1'b0, 32'h0, 32'h00000007, 32'hffffffff);
      runOp("DIV -5/0",      2'b10, 1'b0, 32'hfffffffb, 32'd0,        1'b0, 32'h0, 32'hfffffffb, 32'hffffffff);
      runOp("DIV min/-1",    2'b10, 1'b0, 32'h80000000, 32'hffffffff, 1'b0, 32'h0, 32'h00000000, 32'h80000000);

      applyStimulus(2'b11, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("reserved op busy", 64'(busy), 64'd0);
      @(negedge clock);
      checkOutput("reserved op hi:lo", {hi, lo}, 64'h00000000_80000000);

      applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00000000, 1'b0);
      applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hffffffff, 1'b0);
      checkOutput("MTHI/MTLO hi:lo", {hi, lo}, 64'h00000000_ffffffff);
      runOp("MADDU 1*1",        2'b01, 1'b1, 32'd1, 32'd1, 1'b0, 32'h0, 32'h00000001, 32'h00000000);
      applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000000, 1'b0);
      runOp("MADDU 2*3 + MTHI", 2'b01, 1'b1, 32'd2, 32'd3, 1'b1, 32'd5, 32'h00000005, 32'h00000006);
      runOp("MADD -2*3",        2'b01, 1'b0, 32'hfffffffe, 32'd3, 1'b0, 32'h0, 32'h00000005, 32'h00000000);

      // Flush a divide part-way through CALC
      applyStimulus(2'b10, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0;
      checkOutput("flush busy", 64'(busy), 64'd0);
      checkOutput("flush done", 64'(done), 64'd0);
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("flush no late done", 64'(doneSeen), 64'd0);
      checkOutput("flush hi:lo kept", {hi, lo}, 64'h00000005_00000000);
      runOp("MULTU 6*7 after flush", 2'b00, 1'b1, 32'd6,  32'd7, 1'b0, 32'h0, 32'h00000000, 32'h0000002a);
      runOp("DIVU 50/5 in done cycle", 2'b10, 1'b1, 32'd50, 32'd5, 1'b0, 32'h0, 32'h00000000, 32'h0000000a);

      // Request and MTHI while busy must both be dropped
      applyStimulus(2'b00, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (4) @(negedge clock);
      applyStimulus(2'b10, 1'b1, 32'd100, 32'd7, 1'b1, 1'b1, 32'hdeadbeef, 1'b1);
      begin
         int lat;
         waitDone(lat);
      end
      checkOutput("busy-ignore done seen", 64'(done), 64'd1);
      checkOutput("busy-ignore hi:lo", {hi, lo}, 64'h00000000_0000000c);
      @(negedge clock);
      checkOutput("busy-ignore no second op", 64'(busy), 64'd0);

      // Asynchronous reset in the middle of CALC
      applyStimulus(2'b00, 1'b1, 32'hffffffff, 32'hffffffff, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (5) @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkOutput("mid-op reset busy", 64'(busy), 64'd0);
      checkOutput("mid-op reset done", 64'(done), 64'd0);
      checkOutput("mid-op reset hi:lo", {hi, lo}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      runOp("MULTU 2*3 after reset", 2'b00, 1'b1, 32'd2, 32'd3, 1'b0, 32'h0, 32'h00000000, 32'h00000006);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
